instr_encoder: RTL and testbench

Encodes instruction fields (cond, op, funct, Rn, Rd, Src2/imm24) into 32-bit machine words in the same format the control-unit decoder consumes, then writes them sequentially into instruction memory. It is the program-load path: a testbench or boot controller pushes fields through a valid/ready port, and the block buffers them in a FIFO and writes them over a memory write handshake. It sits between the loader and the instruction memory write port, ahead of the fetch/decode path.

---
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Program-load encoder: packs instruction fields into 32-bit words, queues them and
// writes them to instruction memory. Optional request legality checking: ENC_CHECK_EN.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  input  logic        rewind,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic        mem_ready,
  output logic [7:0]  count,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fifo_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] enc_word;
  logic        fifo_empty, fifo_full;
  logic        accept, illegal, push_req;
  logic        push_fifo, pop_fifo;
  logic        complete, load_slot;

  function automatic logic [31:0] encode(
    input logic [3:0]  f_cond,
    input logic [1:0]  f_op,
    input logic [5:0]  f_funct,
    input logic [3:0]  f_rn,
    input logic [3:0]  f_rd,
    input logic [11:0] f_src2,
    input logic [23:0] f_imm24
  );
    if (f_op == 2'b10) begin
      encode = {f_cond, f_op, f_funct[5:4], f_imm24};
    end else begin
      encode = {f_cond, f_op, f_funct, f_rn, f_rd, f_src2};
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    sat_inc = (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  assign enc_word   = encode(cond, op, funct, rn, rd, src2, imm24);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push_req = accept && !illegal;

`ifdef ENC_CHECK_EN
  logic err_q;

  // Register-shifted-register operands (op 00, funct[5]=0, src2[4]=1) are not supported.
  assign illegal = (op == 2'b11) || ((op == 2'b00) && !funct[5] && src2[4]);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  assign complete  = (state_q == WRITE) && mem_ready;
  assign load_slot = (state_q == IDLE) || complete;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    count_d   = count_q;
    push_fifo = 1'b0;
    pop_fifo  = 1'b0;

    if (complete) begin
      addr_d  = addr_q + 32'd4;
      count_d = sat_inc(count_q);
    end

    if ((state_q == IDLE) && fifo_empty && rewind) begin
      addr_d  = BASE_ADDR;
      count_d = 8'd0;
    end

    // With an empty FIFO the incoming word bypasses straight into the output register,
    // giving one-cycle latency and full throughput when mem_ready stays high.
    if (load_slot) begin
      if (!fifo_empty) begin
        pop_fifo  = 1'b1;
        push_fifo = push_req;
        wd_d      = fifo_q[rd_ptr_q[AW-1:0]];
        state_d   = WRITE;
      end else if (push_req) begin
        wd_d    = enc_word;
        state_d = WRITE;
      end else begin
        state_d = IDLE;
      end
    end else begin
      push_fifo = push_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= BASE_ADDR;
      wd_q     <= 32'd0;
      count_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      count_q <= count_d;
      if (push_fifo) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_fifo) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= enc_word;
    end
  end

  assign mem_we   = (state_q == WRITE);
  assign mem_addr = addr_q;
  assign mem_wd   = wd_q;
  assign count    = count_q;
  assign busy     = !fifo_empty || (state_q == WRITE);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, rewind;
  logic [3:0]  cond, rn, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [11:0] src2;
  logic [23:0] imm24;
  logic        mem_we, mem_ready, busy, err;
  logic [31:0] mem_addr, mem_wd;
  logic [7:0]  count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd), .src2(src2),
    .imm24(imm24), .rewind(rewind), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_ready(mem_ready), .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic [31:0] word;
  } vec_t;

  // Reference encoding built from field weights rather than bit concatenation.
  function automatic logic [31:0] model_enc(input vec_t v);
    logic [31:0] w;
    if (v.op == 2'd2)
      w = 32'(v.cond) * 32'h1000_0000 + 32'(v.op) * 32'h0400_0000 +
          (32'(v.funct) / 32'd16) * 32'h0100_0000 + 32'(v.imm24);
    else
      w = 32'(v.cond) * 32'h1000_0000 + 32'(v.op) * 32'h0400_0000 +
          32'(v.funct) * 32'h0010_0000 + 32'(v.rn) * 32'h0001_0000 +
          32'(v.rd) * 32'h0000_1000 + 32'(v.src2);
    return w;
  endfunction

  function automatic bit model_legal(input vec_t v);
`ifdef ENC_CHECK_EN
    return !((v.op == 2'd3) || ((v.op == 2'd0) && !v.funct[5] && v.src2[4]));
`else
    return 1'b1;
`endif
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.cond  = 4'($urandom);
    v.op    = 2'($urandom);
    v.funct = 6'($urandom);
    v.rn    = 4'($urandom);
    v.rd    = 4'($urandom);
    v.src2  = 12'($urandom);
    v.imm24 = 24'($urandom);
    v.word  = model_enc(v);
    return v;
  endfunction

  function automatic vec_t rand_legal_vec();
    vec_t v;
    v = rand_vec();
    v.op = 2'($urandom_range(0, 2));
    if (v.op == 2'd0) v.funct[5] = 1'b1;
    v.word = model_enc(v);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cond = v.cond; op = v.op; funct = v.funct; rn = v.rn;
    rd = v.rd; src2 = v.src2; imm24 = v.imm24;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; rewind = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                              input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                              input logic [23:0] i, input logic [31:0] w);
    vec_t v;
    v.cond = c; v.op = o; v.funct = f; v.rn = n; v.rd = d; v.src2 = s; v.imm24 = i; v.word = w;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    logic [31:0] exp_q[$];
    logic [31:0] q[$];
    logic [31:0] ea;
    logic [7:0]  ec;
    logic        eerr;
    int          acc, k, sz;

    vecs[0] = mk(4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 12'h005, 24'h0,      32'hE282_1005);
    vecs[1] = mk(4'hE, 2'b01, 6'b011001, 4'h0, 4'h3, 12'h008, 24'h0,      32'hE590_3008);
    vecs[2] = mk(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h000, 24'hFFFFFE, 32'hEAFF_FFFE);
    vecs[3] = mk(4'h1, 2'b10, 6'b011111, 4'hA, 4'h5, 12'hFFF, 24'h123456, 32'h1912_3456);
    vecs[4] = mk(4'hF, 2'b00, 6'b111111, 4'hF, 4'hF, 12'hFFF, 24'hABCDEF, 32'hF3FF_FFFF);
    vecs[5] = mk(4'h0, 2'b01, 6'b000000, 4'h5, 4'hA, 12'h123, 24'h0,      32'h0405_A123);

    mem_ready = 1'b0;
    drive(vecs[0]);
    do_reset();

    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wd", mem_wd, 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Table of single encodings, each written one cycle after accept
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("tbl_mem_we", 32'(mem_we), 32'd1);
      chk("tbl_mem_wd", mem_wd, vecs[i].word);
      chk("tbl_mem_addr", mem_addr, 32'(i * 4));
      tick();
      chk("tbl_idle", 32'(mem_we), 32'd0);
      chk("tbl_count", 32'(count), 32'(i + 1));
    end

    // Back-to-back LDR then B
    do_reset();
    mem_ready = 1'b1;
    drive(vecs[1]); in_valid = 1'b1;
    tick();
    chk("b2b_wd0", mem_wd, 32'hE590_3008);
    chk("b2b_addr0", mem_addr, 32'd0);
    drive(vecs[2]);
    tick();
    in_valid = 1'b0;
    chk("b2b_we1", 32'(mem_we), 32'd1);
    chk("b2b_wd1", mem_wd, 32'hEAFF_FFFE);
    chk("b2b_addr1", mem_addr, 32'd4);
    tick();
    chk("b2b_done", 32'(mem_we), 32'd0);
    chk("b2b_count", 32'(count), 32'd2);
    chk("b2b_addr_end", mem_addr, 32'd8);

    // Rewind when idle is honoured
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    chk("rewind_addr", mem_addr, 32'd0);
    chk("rewind_count", 32'(count), 32'd0);
    drive(vecs[0]); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rewind_count", 32'(count), 32'd1);
    chk("post_rewind_addr", mem_addr, 32'd4);

    // Rewind while busy is ignored
    mem_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    chk("busy_rewind_addr", mem_addr, 32'd4);
    chk("busy_rewind_count", 32'(count), 32'd1);
    chk("busy_rewind_we", 32'(mem_we), 32'd1);
    mem_ready = 1'b1;
    tick();
    chk("busy_rewind_count2", 32'(count), 32'd2);
    chk("busy_rewind_addr2", mem_addr, 32'd8);

    // Backpressure: DEPTH+1 accepts, then drain in order
    do_reset();
    mem_ready = 1'b0;
    acc = 0;
    exp_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!in_ready) break;
      v = rand_legal_vec();
      drive(v);
      exp_q.push_back(v.word);
      tick();
      acc++;
    end
    chk("bp_accepts", 32'(acc), 32'(DEPTH + 1));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    mem_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_we) break;
      if (k < exp_q.size()) begin
        chk("bp_drain_wd", mem_wd, exp_q[k]);
        chk("bp_drain_addr", mem_addr, 32'(k * 4));
      end else begin
        chk("bp_extra_write", 32'd1, 32'd0);
      end
      k++;
      tick();
    end
    chk("bp_drained", 32'(k), 32'(DEPTH + 1));
    chk("bp_count", 32'(count), 32'(DEPTH + 1));
    chk("bp_busy", 32'(busy), 32'd0);

    // Reset while writing with 3 words queued
    do_reset();
    mem_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(rand_legal_vec());
      tick();
    end
    in_valid = 1'b0;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    mem_ready = 1'b1;
    drive(vecs[0]); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("midrst_new_addr", mem_addr, 32'd0);
    chk("midrst_new_wd", mem_wd, 32'hE282_1005);
    tick();

    // op==11 request
    drive(mk(4'h0, 2'b11, 6'b000000, 4'hF, 4'h0, 12'hABC, 24'h0, 32'h0C0F_0ABC));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef ENC_CHECK_EN
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_no_write", 32'(mem_we), 32'd0);
    tick();
    chk("illegal_count", 32'(count), 32'd1);
`else
    chk("op3_err", 32'(err), 32'd0);
    chk("op3_wd", mem_wd, 32'h0C0F_0ABC);
    tick();
    chk("op3_count", 32'(count), 32'd2);
`endif

    // Count saturation at 255 with continuous full-rate writes
    do_reset();
    mem_ready = 1'b1;
    drive(vecs[4]);
    in_valid = 1'b1;
    repeat (260) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_count", 32'(count), 32'd255);
    chk("sat_addr", mem_addr, 32'd1040);
    chk("sat_we", 32'(mem_we), 32'd0);

    // Randomized run against the queue model
    do_reset();
    q.delete();
    ea = 32'd0; ec = 8'd0; eerr = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = rand_vec();
      drive(v);
      in_valid  = ($urandom_range(0, 9) < 6);
      mem_ready = ($urandom_range(0, 9) < 7);
      rewind    = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      sz = q.size();
      chk("rnd_mem_we", 32'(mem_we), 32'(sz != 0));
      chk("rnd_busy", 32'(busy), 32'(sz != 0));
      chk("rnd_in_ready", 32'(in_ready), 32'(sz < DEPTH + 1));
      chk("rnd_count", 32'(count), 32'(ec));
      chk("rnd_addr", mem_addr, ea);
      chk("rnd_err", 32'(err), 32'(eerr));
      if (sz != 0) chk("rnd_mem_wd", mem_wd, q[0]);
      if (sz != 0 && mem_ready) begin
        void'(q.pop_front());
        ea = ea + 32'd4;
        if (ec != 8'd255) ec = ec + 8'd1;
      end
      if (rewind && sz == 0) begin
        ea = 32'd0;
        ec = 8'd0;
      end
      if (in_valid && sz < DEPTH + 1) begin
        if (model_legal(v)) q.push_back(v.word);
        else eerr = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rewind = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
